// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and the instruction memory.
interface fetch_unit_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_ready,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_ready,
    output im_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit: IDLE -> FETCH -> HOLD loop,
// holding one instruction until the core retires it, then fetching the next PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         NPCOp,
  input  logic [25:0]        IMM,
  input  logic               retire,
  fetch_unit_if.master       im,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        PC,
  output logic [31:0]        PC4,
  output logic [31:0]        retire_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] npc;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = {{14{IMM[15]}}, IMM[15:0], 2'b00};

  // Next-PC select; the reserved encoding falls through to sequential.
  always_comb begin
    npc = pc_plus4;
    case (NPCOp)
      NPC_PLUS4:  npc = pc_plus4;
      NPC_BRANCH: npc = pc_plus4 + branch_off;
      NPC_JUMP:   npc = {pc_plus4[31:28], IMM, 2'b00};
      default:    npc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    retire_cnt_d = retire_cnt_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (im.im_ready) begin
          instr_d = im.im_rdata;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (retire) begin
          pc_d         = npc;
          retire_cnt_d = retire_cnt_q + 32'd1;
          state_d      = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= 32'd0;
      retire_cnt_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Outputs decode only from registered state, so no input reaches an output combinationally.
  assign im.im_req   = (state_q == ST_FETCH);
  assign im.im_addr  = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign PC          = pc_q;
  assign PC4         = pc_plus4;
  assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed next-PC table, reset/stall corner cases,
// then randomized fetch/retire traffic against a behavioural PC/counter model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  NPCOp;
  logic [25:0] IMM;
  logic        retire;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic [31:0] retire_cnt;

  fetch_unit_if im_bus ();

  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst         (rst),
    .NPCOp       (NPCOp),
    .IMM         (IMM),
    .retire      (retire),
    .im          (im_bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .PC          (PC),
    .PC4         (PC4),
    .retire_cnt  (retire_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  typedef struct {
    logic [1:0]  op;
    logic [25:0] imm;
    logic [31:0] pc_before;
    logic [31:0] next_pc;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule, written as plain arithmetic.
  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [1:0] op,
                                            input logic [25:0] imm);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    off = $signed(imm[15:0]);
    case (op)
      2'd1:    return seq + 32'(off * 4);
      2'd2:    return (seq & 32'hF000_0000) | (32'(imm) * 32'd4);
      default: return seq;
    endcase
  endfunction

  task automatic fetch_word(input logic [31:0] word, input int stall, input bit pulse_retire);
    check("fetch_req", 32'(im_bus.im_req), 32'd1);
    check("fetch_addr", im_bus.im_addr, m_pc);
    for (int i = 0; i < stall; i++) begin
      im_bus.im_ready = 1'b0;
      retire = pulse_retire;
      NPCOp  = 2'b01;
      IMM    = 26'($urandom);
      step();
      check("stall_req", 32'(im_bus.im_req), 32'd1);
      check("stall_addr", im_bus.im_addr, m_pc);
      check("stall_valid", 32'(instr_valid), 32'd0);
      check("stall_pc", PC, m_pc);
      check("stall_cnt", retire_cnt, m_cnt);
    end
    retire          = 1'b0;
    im_bus.im_ready = 1'b1;
    im_bus.im_rdata = word;
    step();
    im_bus.im_ready = 1'b0;
    im_bus.im_rdata = $urandom;
    check("got_valid", 32'(instr_valid), 32'd1);
    check("got_instr", instr, word);
    check("got_req", 32'(im_bus.im_req), 32'd0);
    check("got_pc", PC, m_pc);
  endtask

  task automatic hold_and_retire(input logic [1:0] op, input logic [25:0] imm, input int hold,
                                 input bit noise, input logic [31:0] word);
    for (int i = 0; i < hold; i++) begin
      retire          = 1'b0;
      im_bus.im_ready = noise;
      im_bus.im_rdata = $urandom;
      step();
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_instr", instr, word);
      check("hold_pc", PC, m_pc);
      check("hold_pc4", PC4, m_pc + 32'd4);
    end
    im_bus.im_ready = 1'b0;
    retire = 1'b1;
    NPCOp  = op;
    IMM    = imm;
    step();
    retire = 1'b0;
    m_pc   = model_npc(m_pc, op, imm);
    m_cnt  = m_cnt + 32'd1;
    check("ret_pc", PC, m_pc);
    check("ret_cnt", retire_cnt, m_cnt);
    check("ret_req", 32'(im_bus.im_req), 32'd1);
    check("ret_valid", 32'(instr_valid), 32'd0);
    check("ret_addr", im_bus.im_addr, m_pc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'b00, 26'h0000000, 32'h0000_3000, 32'h0000_3004};
    vecs[1] = '{2'b01, 26'h000FFFF, 32'h0000_3004, 32'h0000_3004};
    vecs[2] = '{2'b00, 26'h0000000, 32'h0000_3004, 32'h0000_3008};
    vecs[3] = '{2'b10, 26'h0000C04, 32'h0000_3008, 32'h0000_3010};
    vecs[4] = '{2'b01, 26'h000F3FA, 32'h0000_3010, 32'hFFFF_FFFC};
    vecs[5] = '{2'b00, 26'h0000000, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[6] = '{2'b11, 26'h3FFFFFF, 32'h0000_0000, 32'h0000_0004};

    rst = 1'b1; retire = 1'b0; NPCOp = 2'b00; IMM = '0;
    im_bus.im_ready = 1'b0; im_bus.im_rdata = '0;
    step();
    step();
    check("rst_req", 32'(im_bus.im_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", PC, 32'h0000_3000);
    check("rst_cnt", retire_cnt, 32'd0);
    check("rst_instr", instr, 32'd0);

    // First cycle after release is IDLE; a retire here must be ignored.
    rst = 1'b0;
    m_pc = 32'h0000_3000;
    m_cnt = 32'd0;
    check("idle_req", 32'(im_bus.im_req), 32'd0);
    retire = 1'b1; NPCOp = 2'b01; IMM = 26'h0000040;
    step();
    retire = 1'b0;
    check("idle_ret_pc", PC, 32'h0000_3000);
    check("idle_ret_cnt", retire_cnt, 32'd0);
    check("lat_req", 32'(im_bus.im_req), 32'd1);
    check("lat_addr", im_bus.im_addr, 32'h0000_3000);

    for (int i = 0; i < 7; i++) begin
      logic [31:0] word;
      int          stall;
      word  = $urandom;
      stall = (i == 0) ? 0 : ((i == 1) ? 5 : i % 3);
      fetch_word(word, stall, i == 2);
      check($sformatf("vec%0d_pc", i), PC, vecs[i].pc_before);
      check($sformatf("vec%0d_pc4", i), PC4, vecs[i].pc_before + 32'd4);
      hold_and_retire(vecs[i].op, vecs[i].imm, i % 2, i == 3, word);
      check($sformatf("vec%0d_npc", i), PC, vecs[i].next_pc);
      $display("[TB] vec %0d op=%b imm=%h pc=%h -> %h cnt=%0d", i, vecs[i].op, vecs[i].imm,
               vecs[i].pc_before, PC, retire_cnt);
    end

    // Reset lands on the same edge as im_ready during FETCH.
    rst = 1'b1;
    im_bus.im_ready = 1'b1;
    im_bus.im_rdata = 32'hDEAD_BEEF;
    step();
    check("midrst_req", 32'(im_bus.im_req), 32'd0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_pc", PC, 32'h0000_3000);
    check("midrst_cnt", retire_cnt, 32'd0);
    check("midrst_instr", instr, 32'd0);
    rst = 1'b0;
    step();
    check("late_rdy_req", 32'(im_bus.im_req), 32'd1);
    check("late_rdy_valid", 32'(instr_valid), 32'd0);
    check("late_rdy_instr", instr, 32'd0);
    im_bus.im_ready = 1'b0;
    m_pc = 32'h0000_3000;
    m_cnt = 32'd0;
    $display("[TB] mid-fetch reset pc=%h cnt=%0d", PC, retire_cnt);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] word;
      logic [1:0]  op;
      logic [25:0] imm;
      word = $urandom;
      op   = 2'($urandom_range(0, 3));
      imm  = 26'($urandom);
      fetch_word(word, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      hold_and_retire(op, imm, $urandom_range(0, 2), 1'($urandom_range(0, 1)), word);
      $display("[TB] rnd %0d op=%b imm=%h -> pc=%h cnt=%0d", n, op, imm, PC, retire_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
